mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive MEM grants while IF waits (used only with MEM_ARB_STARVE_EN).
REQ-002 SHALL have ports in this order, with reset rst synchronous and active-high, and clock clk:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  if_req  in  1  fetch request; held until if_ack
  if_addr  in  32  fetch address
  if_rdata  out  32  fetched instruction
  if_ack  out  1  fetch done, one-cycle pulse
  mem_req  in  1  data request; held until mem_ack
  mem_we  in  1  1 = write
  mem_sel  in  4  byte enables
  mem_addr  in  32  data address
  mem_wdata  in  32  store data
  mem_rdata  out  32  load data
  mem_ack  out  1  data done, one-cycle pulse
  flush  in  1  pipeline redirect; discard the in-flight fetch
  ram_req  out  1  shared port request
  ram_we  out  1  shared port write
  ram_sel  out  4  shared port byte enables
  ram_addr  out  32  shared port address
  ram_wdata  out  32  shared port write data
  ram_rdata  in  32  shared port read data
  ram_ack  in  1  shared port completion, one cycle, latency 1..N
  stallreq_if  out  1  fetch stage stall request
  stallreq_mem  out  1  memory stage stall request

Function
REQ-003 SHALL implement the FSM states IDLE, IF_ACC, MEM_ACC and IF_DROP.
REQ-004 In IDLE: if mem_req, SHALL go to MEM_ACC; else if if_req and not flush, SHALL go to IF_ACC; else SHALL stay in IDLE.
REQ-005 SHALL drive ram_req/ram_we/ram_sel/ram_addr/ram_wdata from registers captured at grant, held stable until ram_ack; ram_we=0 and ram_sel=4'hF for IF.
REQ-006 In IF_ACC/MEM_ACC with ram_ack: SHALL pulse if_ack/mem_ack combinationally that cycle, pass ram_rdata to if_rdata/mem_rdata, drop ram_req next cycle and return to IDLE.
REQ-007 Minimum access: request seen at cycle N, ram_req high at N+1, ack no earlier than N+1; there SHALL be no back-to-back grant without passing through IDLE.
REQ-008 flush in IF_ACC (before or with ram_ack) SHALL go to IF_DROP or IDLE: ram_req held until ram_ack, if_ack suppressed; IF_DROP exits to IDLE on ram_ack.
REQ-009 MEM accesses SHALL never be aborted by flush.
REQ-010 stallreq_if SHALL equal if_req & ~if_ack; stallreq_mem SHALL equal mem_req & ~mem_ack.
REQ-011 if_rdata/mem_rdata SHALL be 0 when the matching ack is low.

Reset
REQ-012 rst SHALL force IDLE and zero all registered ram_* outputs and the starvation counter at the next edge, including mid-access; a late ram_ack in IDLE SHALL be ignored.

Configuration
REQ-013 With MEM_ARB_STARVE_EN defined: a counter SHALL increment on each MEM grant while if_req is high, clear on an IF grant, and once it reaches STARVE_LIMIT the IDLE priority SHALL invert for one grant (IF wins).
REQ-014 Without MEM_ARB_STARVE_EN: strict MEM-over-IF priority, no counter logic.

Structure
REQ-015 FSM state encoding and the 32-bit word/byte-enable width constants SHALL live in the shared package/define file.
REQ-016 Single module; no sub-module required.

Verification
REQ-017 IF only, ram_ack latency 1: if_req at cycle 0, addr 0x100 -> ram_req at 1, if_ack at 1 with rdata 0x12345678.
REQ-018 Simultaneous if_req and mem_req (store 0xDEADBEEF, sel 4'b0011) -> MEM served first, IF granted after return to IDLE; stallreq_if high throughout.
REQ-019 flush at cycle 2 of a 4-cycle IF access -> ram_req held until ram_ack, no if_ack, IDLE the cycle after.
REQ-020 rst at cycle 2 of a MEM access -> ram_req 0 at cycle 3, subsequent stray ram_ack produces no ack.
REQ-021 MEM_ARB_STARVE_EN, STARVE_LIMIT=4, mem_req and if_req held continuously -> grant pattern M,M,M,M,I repeating.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM shared-port arbiter: FSM encoding and bus widths.
package mem_arb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_ALL = SEL_W'('1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2,
    IF_DROP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb.sv
// Arbiter sharing one RAM port between instruction fetch and data memory stages.
// Optional anti-starvation for fetch is enabled by defining MEM_ARB_STARVE_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_ack,
  input  logic              flush,
  output logic              ram_req,
  output logic              ram_we,
  output logic [SEL_W-1:0]  ram_sel,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  arb_state_t state;
  logic       if_grant;
  logic       mem_grant;

  // A zero limit would hand every IDLE cycle to fetch; reject it at elaboration.
  if (STARVE_LIMIT == 0) begin : g_limit_check
    $error("mem_arb: STARVE_LIMIT must be nonzero");
  end

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved   = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign if_grant  = (state == IDLE) && if_req && !flush && (starved || !mem_req);
  assign mem_grant = (state == IDLE) && mem_req && !if_grant;

  // Counts MEM wins over a waiting fetch; saturates so a flushed IF keeps its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_grant) begin
      starve_cnt <= '0;
    end else if (mem_grant && if_req && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign mem_grant = (state == IDLE) && mem_req;
  assign if_grant  = (state == IDLE) && if_req && !flush && !mem_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_sel   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_grant) begin
            state     <= MEM_ACC;
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_sel   <= mem_sel;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (if_grant) begin
            state     <= IF_ACC;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_sel   <= SEL_ALL;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
          end
        end
        // A flush leaves the RAM transaction running but forgets its result.
        IF_ACC: begin
          if (ram_ack) begin
            state   <= IDLE;
            ram_req <= 1'b0;
          end else if (flush) begin
            state <= IF_DROP;
          end
        end
        MEM_ACC, IF_DROP: begin
          if (ram_ack) begin
            state   <= IDLE;
            ram_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_ack       = (state == IF_ACC) && ram_ack && !flush;
  assign mem_ack      = (state == MEM_ACC) && ram_ack;
  assign if_rdata     = if_ack  ? ram_rdata : '0;
  assign mem_rdata    = mem_ack ? ram_rdata : '0;
  assign stallreq_if  = if_req  && !if_ack;
  assign stallreq_mem = mem_req && !mem_ack;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a variable-latency RAM model on the shared port.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        flush;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stallreq_if;
  logic        stallreq_mem;

  int unsigned lat       = 1;
  int unsigned wait_cnt  = 0;
  logic        stray_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .flush(flush),
    .ram_req(ram_req), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  // RAM acks in the lat-th cycle of ram_req; data is 0x12345678 at 0x100, else ~addr.
  always @(posedge clk) begin
    if (!ram_req || ram_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end
  assign ram_ack   = (ram_req && (wait_cnt == lat - 1)) || stray_ack;
  assign ram_rdata = ram_ack ? ((ram_addr == 32'h100) ? 32'h1234_5678 : ~ram_addr) : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic grants [10];
    int   n_grants;
    logic exp_we;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_sel = '0; mem_addr = '0; mem_wdata = '0; flush = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_ram_req", 32'(ram_req), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_sel", 32'(ram_sel), 32'h0);
    check("rst_if_ack", 32'(if_ack), 32'h0);

    // Fetch only, latency 1
    next_cycle();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; lat = 1;
    @(negedge clk);
    check("if1_c0_ram_req", 32'(ram_req), 32'h0);
    check("if1_c0_stall_if", 32'(stallreq_if), 32'h1);
    next_cycle();
    @(negedge clk);
    check("if1_c1_ram_req", 32'(ram_req), 32'h1);
    check("if1_c1_ram_addr", ram_addr, 32'h100);
    check("if1_c1_ram_we", 32'(ram_we), 32'h0);
    check("if1_c1_ram_sel", 32'(ram_sel), 32'hF);
    check("if1_c1_if_ack", 32'(if_ack), 32'h1);
    check("if1_c1_if_rdata", if_rdata, 32'h1234_5678);
    check("if1_c1_stall_if", 32'(stallreq_if), 32'h0);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("if1_c2_ram_req", 32'(ram_req), 32'h0);
    check("if1_c2_if_rdata", if_rdata, 32'h0);

    // Simultaneous MEM store and IF fetch, latency 2; flush must not abort MEM
    next_cycle();
    lat = 2;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    check("both_c0_stall_if", 32'(stallreq_if), 32'h1);
    check("both_c0_stall_mem", 32'(stallreq_mem), 32'h1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("both_c1_ram_req", 32'(ram_req), 32'h1);
    check("both_c1_ram_we", 32'(ram_we), 32'h1);
    check("both_c1_ram_sel", 32'(ram_sel), 32'h3);
    check("both_c1_ram_addr", ram_addr, 32'h200);
    check("both_c1_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("both_c1_mem_ack", 32'(mem_ack), 32'h0);
    check("both_c1_stall_if", 32'(stallreq_if), 32'h1);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("both_c2_mem_ack", 32'(mem_ack), 32'h1);
    check("both_c2_mem_rdata", mem_rdata, 32'hFFFF_FDFF);
    check("both_c2_stall_mem", 32'(stallreq_mem), 32'h0);
    check("both_c2_stall_if", 32'(stallreq_if), 32'h1);
    next_cycle();
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("both_c3_ram_req", 32'(ram_req), 32'h0);
    check("both_c3_stall_if", 32'(stallreq_if), 32'h1);
    next_cycle();
    @(negedge clk);
    check("both_c4_ram_addr", ram_addr, 32'h104);
    check("both_c4_ram_we", 32'(ram_we), 32'h0);
    check("both_c4_ram_sel", 32'(ram_sel), 32'hF);
    check("both_c4_if_ack", 32'(if_ack), 32'h0);
    next_cycle();
    @(negedge clk);
    check("both_c5_if_ack", 32'(if_ack), 32'h1);
    check("both_c5_if_rdata", if_rdata, 32'hFFFF_FEFB);
    next_cycle();
    if_req = 1'b0;

    // Flush in cycle 2 of a 4-cycle fetch
    next_cycle();
    lat = 4; if_req = 1'b1; if_addr = 32'h108;
    next_cycle();
    @(negedge clk);
    check("fl_c1_ram_req", 32'(ram_req), 32'h1);
    next_cycle();
    if_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_c2_if_ack", 32'(if_ack), 32'h0);
    check("fl_c2_ram_req", 32'(ram_req), 32'h1);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("fl_c3_ram_req", 32'(ram_req), 32'h1);
    next_cycle();
    @(negedge clk);
    check("fl_c4_ram_ack", 32'(ram_ack), 32'h1);
    check("fl_c4_if_ack", 32'(if_ack), 32'h0);
    check("fl_c4_if_rdata", if_rdata, 32'h0);
    next_cycle();
    lat = 1; if_req = 1'b1; if_addr = 32'h10C;
    @(negedge clk);
    check("fl_c5_ram_req", 32'(ram_req), 32'h0);
    next_cycle();
    @(negedge clk);
    check("fl_c6_ram_addr", ram_addr, 32'h10C);
    check("fl_c6_if_ack", 32'(if_ack), 32'h1);
    next_cycle();
    if_req = 1'b0;

    // Reset in cycle 2 of a MEM read, then a stray ack
    next_cycle();
    lat = 4; mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_c2_ram_req", 32'(ram_req), 32'h1);
    next_cycle();
    rst = 1'b0; mem_req = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    check("rst_c3_ram_req", 32'(ram_req), 32'h0);
    check("rst_c3_ram_addr", ram_addr, 32'h0);
    check("rst_c3_mem_ack", 32'(mem_ack), 32'h0);
    check("rst_c3_if_ack", 32'(if_ack), 32'h0);
    check("rst_c3_mem_rdata", mem_rdata, 32'h0);
    next_cycle();
    stray_ack = 1'b0;
    @(negedge clk);
    check("rst_c4_ram_req", 32'(ram_req), 32'h0);

    // Both requests held continuously: record who wins each grant (ram_we=1 marks MEM)
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; lat = 1;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h400; mem_wdata = 32'h1;
    if_req = 1'b1; if_addr = 32'h500;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 10; c++) begin
      @(negedge clk);
      if (ram_req && ram_ack) begin
        grants[n_grants] = ram_we;
        n_grants++;
      end
      next_cycle();
    end
    check("hold_grant_count", 32'(n_grants), 32'd10);
    for (int k = 0; k < n_grants; k++) begin
`ifdef MEM_ARB_STARVE_EN
      exp_we = (k % 5 == 4) ? 1'b0 : 1'b1;
`else
      exp_we = 1'b1;
`endif
      check($sformatf("hold_grant_%0d", k), 32'(grants[k]), 32'(exp_we));
    end
    mem_req = 1'b0; if_req = 1'b0;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
